id_ex_pipe: RTL
===============

Name: id_ex_pipe

Overview:
- ID/EX pipeline register directly upstream of the EX-stage ALU operand mux.
- Latches decoded operands, PC, immediate, register addresses and control bits from ID, and presents them to EX as the *_ex signals.
- Contains the load-use hazard detector and inserts bubbles on hazard or branch flush.
- Keeps a saturating count of inserted load-use bubbles.

Parameters:
- CNT_WIDTH, 16, width of the load-use bubble counter.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-low.
- read_data1_id  in  `REG_DATA_WIDTH  rs1 value from the register file.
- read_data2_id  in  `REG_DATA_WIDTH  rs2 value from the register file.
- pc_id  in  `PC_WIDTH  PC of the ID instruction.
- immediate_id  in  `IMM_WIDTH  decoded immediate.
- rs1_id, rs2_id, rd_id  in  5 each  register addresses.
- use_rs1_id, use_rs2_id  in  1 each  instruction actually reads rs1/rs2.
- ctrl_id  in  `CTRL_WIDTH  packed control: aluinputpc, alusrc, aluop[3:0], memread, memwrite, memtoreg, regwrite, branch, jump.
- valid_id  in  1  ID holds a real instruction.
- flush_ex  in  1  branch/jump resolved taken in EX; kill the ID instruction.
- stall_ex  in  1  downstream busy; freeze ID/EX.
- wb_regwrite, wb_rd  in  1, 5  WB-stage write port (used only by the optional feature).
- write_data_wb  in  `REG_DATA_WIDTH  WB-stage write data (used only by the optional feature).
- read_data1_ex, read_data2_ex, pc_ex, immediate_ex  out  widths as inputs  registered operands.
- rs1_ex, rs2_ex, rd_ex  out  5 each  registered addresses, consumed by the forwarding unit.
- ctrl_ex  out  `CTRL_WIDTH  registered control; aluinputpc_ex and alusrc_ex are sliced from it.
- valid_ex  out  1  EX holds a real instruction.
- load_use_stall  out  1  combinational; holds PC and IF/ID.
- bubble_cnt  out  CNT_WIDTH  saturating count of load-use bubbles.

Behaviour:
- Reset (rst=0, asynchronous):
  - all *_ex outputs, valid_ex and bubble_cnt are 0; a bubble is in EX.
  - load_use_stall is 0 while in reset.
- Hazard detection (combinational):
  - load_use_stall = valid_ex & ctrl_ex.memread & (rd_ex!=0) & valid_id & ((use_rs1_id & rs1_id==rd_ex) | (use_rs2_id & rs2_id==rd_ex)).
  - load_use_stall is forced 0 when flush_ex=1 or stall_ex=1.
- Per-edge update priority (first match wins):
  1. flush_ex=1: load bubble.
  2. stall_ex=1: hold every register unchanged.
  3. load_use_stall=1: load bubble.
  4. Otherwise: load all *_id inputs into *_ex.
- Bubble content:
  - ctrl_ex=0 (regwrite, memwrite, memread, branch and jump all 0), valid_ex=0.
  - data, PC and address registers are all zeroed so waveforms stay clean.
- Latency: one cycle ID→EX. A load-use hazard costs exactly one bubble; the following cycle the forwarding path supplies the MEM-stage data.
- Back-to-back loads feeding a dependent instruction: one bubble per dependent pair, never two for the same pair.
- flush_ex together with a load-use condition: flush wins; bubble_cnt does not increment.
- bubble_cnt:
  - increments only on edges where case 3 is taken.
  - saturates at all-ones; no wrap.
- An rd_ex=0 load never triggers a stall.
- Reset asserted mid-stall clears everything; the first edge after release performs a normal load.

Optional Feature:
- Macro: RISCV_WB_BYPASS_EN.
- Defined:
  - On a case-4 load, if wb_regwrite & wb_rd!=0 & wb_rd==rs1_id, read_data1_ex takes write_data_wb instead of read_data1_id.
  - The same rule applies to rs2 / read_data2_ex.
  - This covers register files without write-before-read; the forwarding unit then never needs the 3-cycle-distance case.
- Not defined:
  - wb_regwrite, wb_rd and write_data_wb are ignored (left unconnected internally).
  - operands are latched straight from the *_id inputs.

Decomposition:
- riscv_def.v gains:
  - `CTRL_WIDTH
  - control-bit index macros (`CTRL_MEMREAD, `CTRL_REGWRITE, `CTRL_ALUSRC, `CTRL_ALUINPUTPC, …)
  - `REG_ADDR_WIDTH (5)
- Sub-module hazard_detect: purely the combinational load_use_stall equation, reusable by the IF/ID register.

Test Plan:
- Reset release: rst held 0 for 3 cycles with nonzero inputs → all outputs 0; after release, pc_id=0x40 appears as pc_ex=0x40 one edge later with valid_ex=1.
- Load-use: EX holds lw x5 (memread=1, rd=5); ID holds add using rs1=5 → load_use_stall=1 that cycle; next edge gives valid_ex=0, ctrl_ex=0, bubble_cnt=1; following edge loads the add.
- No false stall: EX holds lw x0, or ID has use_rs2_id=0 with rs2_id=5 → load_use_stall=0, no bubble.
- Flush vs hazard: flush_ex=1 in the same cycle as a load-use condition → bubble loaded, load_use_stall=0, bubble_cnt unchanged.
- Stall hold: stall_ex=1 for 4 cycles with changing *_id inputs → *_ex stay frozen; release gives a normal load.
- Bypass (RISCV_WB_BYPASS_EN defined): wb_regwrite=1, wb_rd=7, write_data_wb=0xDEADBEEF, rs1_id=7, read_data1_id=0x1 → read_data1_ex=0xDEADBEEF. Same stimulus with the macro undefined → read_data1_ex=0x1.

Source files
------------

// File: rtl/id_ex_pipe_pkg.sv
// Shared widths, control-bit layout and the ID/EX bundle type for the pipeline slice.
// Also hosts the global width/index macros used in port declarations.
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef IMM_WIDTH
`define IMM_WIDTH 32
`endif
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef CTRL_WIDTH
`define CTRL_WIDTH 12
`define CTRL_JUMP 0
`define CTRL_BRANCH 1
`define CTRL_REGWRITE 2
`define CTRL_MEMTOREG 3
`define CTRL_MEMWRITE 4
`define CTRL_MEMREAD 5
`define CTRL_ALUOP_LO 6
`define CTRL_ALUOP_HI 9
`define CTRL_ALUSRC 10
`define CTRL_ALUINPUTPC 11
`endif

package id_ex_pipe_pkg;

    localparam int REG_DATA_W = `REG_DATA_WIDTH;
    localparam int PC_W       = `PC_WIDTH;
    localparam int IMM_W      = `IMM_WIDTH;
    localparam int REG_ADDR_W = `REG_ADDR_WIDTH;
    localparam int CTRL_W     = `CTRL_WIDTH;

    localparam int CTRL_MEMREAD_IDX    = `CTRL_MEMREAD;
    localparam int CTRL_REGWRITE_IDX   = `CTRL_REGWRITE;
    localparam int CTRL_ALUSRC_IDX     = `CTRL_ALUSRC;
    localparam int CTRL_ALUINPUTPC_IDX = `CTRL_ALUINPUTPC;

    // Everything that travels from ID to EX; an all-zero value is a bubble.
    typedef struct packed {
        logic                  valid;
        logic [CTRL_W-1:0]     ctrl;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic [PC_W-1:0]       pc;
        logic [IMM_W-1:0]      imm;
        logic [REG_DATA_W-1:0] data1;
        logic [REG_DATA_W-1:0] data2;
    } ex_bundle_t;

    function automatic logic ctrl_memread(input logic [CTRL_W-1:0] ctrl);
        return ctrl[CTRL_MEMREAD_IDX];
    endfunction

    function automatic logic addr_match_nz(input logic [REG_ADDR_W-1:0] a,
                                           input logic [REG_ADDR_W-1:0] b);
        return (a == b) && (a != {REG_ADDR_W{1'b0}});
    endfunction

endpackage

// File: rtl/id_ex_pipe_hazard_detect.sv
// Combinational load-use hazard detector; shared with the IF/ID register so both
// stages agree on when to hold.
module hazard_detect
    import id_ex_pipe_pkg::*;
(
    input  logic                  valid_ex,
    input  logic                  memread_ex,
    input  logic [REG_ADDR_W-1:0] rd_ex,
    input  logic                  valid_id,
    input  logic                  use_rs1_id,
    input  logic [REG_ADDR_W-1:0] rs1_id,
    input  logic                  use_rs2_id,
    input  logic [REG_ADDR_W-1:0] rs2_id,
    input  logic                  flush_ex,
    input  logic                  stall_ex,
    output logic                  load_use_stall
);

    logic dep_s;

    // A dependent operand is one actually read and named by the load's rd (x0 excluded).
    always_comb begin
        dep_s = (use_rs1_id && addr_match_nz(rs1_id, rd_ex)) ||
                (use_rs2_id && addr_match_nz(rs2_id, rd_ex));
    end

    // Flush and downstream stall already keep ID out of EX, so no extra hold is needed.
    always_comb begin
        if (flush_ex || stall_ex) begin
            load_use_stall = 1'b0;
        end else begin
            load_use_stall = valid_ex && memread_ex && valid_id && dep_s;
        end
    end

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use bubble insertion and a saturating bubble counter.
// Optional macro RISCV_WB_BYPASS_EN captures same-cycle WB writes into the latched operands.
module id_ex_pipe
    import id_ex_pipe_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [`REG_DATA_WIDTH-1:0]  read_data1_id,
    input  logic [`REG_DATA_WIDTH-1:0]  read_data2_id,
    input  logic [`PC_WIDTH-1:0]        pc_id,
    input  logic [`IMM_WIDTH-1:0]       immediate_id,
    input  logic [`REG_ADDR_WIDTH-1:0]  rs1_id,
    input  logic [`REG_ADDR_WIDTH-1:0]  rs2_id,
    input  logic [`REG_ADDR_WIDTH-1:0]  rd_id,
    input  logic                        use_rs1_id,
    input  logic                        use_rs2_id,
    input  logic [`CTRL_WIDTH-1:0]      ctrl_id,
    input  logic                        valid_id,
    input  logic                        flush_ex,
    input  logic                        stall_ex,
    input  logic                        wb_regwrite,
    input  logic [`REG_ADDR_WIDTH-1:0]  wb_rd,
    input  logic [`REG_DATA_WIDTH-1:0]  write_data_wb,
    output logic [`REG_DATA_WIDTH-1:0]  read_data1_ex,
    output logic [`REG_DATA_WIDTH-1:0]  read_data2_ex,
    output logic [`PC_WIDTH-1:0]        pc_ex,
    output logic [`IMM_WIDTH-1:0]       immediate_ex,
    output logic [`REG_ADDR_WIDTH-1:0]  rs1_ex,
    output logic [`REG_ADDR_WIDTH-1:0]  rs2_ex,
    output logic [`REG_ADDR_WIDTH-1:0]  rd_ex,
    output logic [`CTRL_WIDTH-1:0]      ctrl_ex,
    output logic                        valid_ex,
    output logic                        load_use_stall,
    output logic [CNT_WIDTH-1:0]        bubble_cnt
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    ex_bundle_t            ex_r;
    ex_bundle_t            id_s;
    logic [CNT_WIDTH-1:0]  bubble_cnt_r;
    logic                  load_use_stall_s;
    logic [REG_DATA_W-1:0] op1_s;
    logic [REG_DATA_W-1:0] op2_s;

`ifdef RISCV_WB_BYPASS_EN
    // Register file lacks write-before-read, so a WB write to a source register wins here.
    always_comb begin
        if (wb_regwrite && addr_match_nz(wb_rd, rs1_id)) begin
            op1_s = write_data_wb;
        end else begin
            op1_s = read_data1_id;
        end
        if (wb_regwrite && addr_match_nz(wb_rd, rs2_id)) begin
            op2_s = write_data_wb;
        end else begin
            op2_s = read_data2_id;
        end
    end
`else
    logic unused_wb_s;
    assign unused_wb_s = ^{wb_regwrite, wb_rd, write_data_wb};
    assign op1_s = read_data1_id;
    assign op2_s = read_data2_id;
`endif

    // Gather the ID-side bundle that a normal advance would latch.
    always_comb begin
        id_s       = '0;
        id_s.valid = valid_id;
        id_s.ctrl  = ctrl_id;
        id_s.rs1   = rs1_id;
        id_s.rs2   = rs2_id;
        id_s.rd    = rd_id;
        id_s.pc    = pc_id;
        id_s.imm   = immediate_id;
        id_s.data1 = op1_s;
        id_s.data2 = op2_s;
    end

    hazard_detect u_hazard_detect (
        .valid_ex       (ex_r.valid),
        .memread_ex     (ctrl_memread(ex_r.ctrl)),
        .rd_ex          (ex_r.rd),
        .valid_id       (valid_id),
        .use_rs1_id     (use_rs1_id),
        .rs1_id         (rs1_id),
        .use_rs2_id     (use_rs2_id),
        .rs2_id         (rs2_id),
        .flush_ex       (flush_ex),
        .stall_ex       (stall_ex),
        .load_use_stall (load_use_stall_s)
    );

    // Pipeline register: flush beats stall, stall beats hazard bubble, else advance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_r <= '0;
        end else if (flush_ex) begin
            ex_r <= '0;
        end else if (stall_ex) begin
            ex_r <= ex_r;
        end else if (load_use_stall_s) begin
            ex_r <= '0;
        end else begin
            ex_r <= id_s;
        end
    end

    // Counts only hazard bubbles; the stall signal is already masked by flush and stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bubble_cnt_r <= '0;
        end else if (load_use_stall_s && (bubble_cnt_r != CNT_MAX)) begin
            bubble_cnt_r <= bubble_cnt_r + CNT_ONE;
        end else begin
            bubble_cnt_r <= bubble_cnt_r;
        end
    end

    assign read_data1_ex  = ex_r.data1;
    assign read_data2_ex  = ex_r.data2;
    assign pc_ex          = ex_r.pc;
    assign immediate_ex   = ex_r.imm;
    assign rs1_ex         = ex_r.rs1;
    assign rs2_ex         = ex_r.rs2;
    assign rd_ex          = ex_r.rd;
    assign ctrl_ex        = ex_r.ctrl;
    assign valid_ex       = ex_r.valid;
    assign bubble_cnt     = bubble_cnt_r;
    assign load_use_stall = load_use_stall_s;

endmodule
